// File: rtl/mesh_torus_link_pipe_if.sv
// Flit/credit link bundle between an upstream router output and the pipelined link.
// The slave view belongs to the link pipe; the master view belongs to the router side.
interface mesh_torus_link_pipe_if #(
  parameter int Fw = 32,
  parameter int V  = 2
);
  logic          up_flit_wr;
  logic [Fw-1:0] up_flit;
  logic [V-1:0]  up_vc;
  logic [V-1:0]  up_credit_avail;
  logic          dn_flit_wr;
  logic [Fw-1:0] dn_flit;
  logic [V-1:0]  dn_vc;
  logic [V-1:0]  dn_credit_in;

  modport slave (
    input  up_flit_wr, up_flit, up_vc, dn_credit_in,
    output up_credit_avail, dn_flit_wr, dn_flit, dn_vc
  );

  modport master (
    output up_flit_wr, up_flit, up_vc, dn_credit_in,
    input  up_credit_avail, dn_flit_wr, dn_flit, dn_vc
  );
endinterface

// File: rtl/mesh_torus_link_pipe.sv
// Pipelined NoC link: flits travel forward and credits travel back through LINK_DEPTH stages.
// Per-VC credit counters gate upstream writes, and a sleep FSM drains the link before power-gating.
module mesh_torus_link_pipe #(
  parameter int NOC_ID     = 0,
  parameter int Fw         = 32,
  parameter int V          = 2,
  parameter int B          = 4,
  parameter int LINK_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sleep_req,
  output logic [1:0]             link_state,
  output logic                   link_idle,
  output logic                   credit_err,
  mesh_torus_link_pipe_if.slave  link
);

  localparam int CW = $clog2(B + 1);
  localparam int LD = LINK_DEPTH;
  localparam logic [CW-1:0] FULL = CW'(B);

  if (LINK_DEPTH < 1 || LINK_DEPTH > 4 || NOC_ID < 0) begin : g_badParam
    $error("mesh_torus_link_pipe: LINK_DEPTH must be 1..4 and NOC_ID non-negative");
  end

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_OFF    = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_fwdValid [LD];
  logic [Fw-1:0] r_fwdFlit  [LD];
  logic [V-1:0]  r_fwdVc    [LD];
  logic [V-1:0]  r_crdPipe  [LD];
  logic [CW-1:0] r_cnt      [V];
  logic          r_creditErr;

  logic          w_active;
  logic          w_accept;
  logic [V-1:0]  w_avail;
  logic [V-1:0]  w_crdIn;
  logic [V-1:0]  w_inc;
  logic [V-1:0]  w_dec;
  logic          w_pipesEmpty;
  logic          w_allFull;
  logic          w_overflow;
  logic          w_violation;

  assign w_active = (r_state == ST_ACTIVE);

  always_comb begin
    w_avail = '0;
    for (int i = 0; i < V; i++) begin
      w_avail[i] = (r_cnt[i] != '0) && w_active;
    end
  end

  // The one-hot test keeps a multi-bit VC from sneaking through on one VC's credit.
  assign w_accept = link.up_flit_wr && $onehot(link.up_vc) && ((link.up_vc & w_avail) != '0);
  assign w_dec    = w_accept ? link.up_vc : '0;
  assign w_inc    = r_crdPipe[LD-1];
  assign w_crdIn  = (r_state == ST_OFF) ? '0 : link.dn_credit_in;

  // A credit arriving while the same VC is written cancels out, so it can never overflow.
  always_comb begin
    w_pipesEmpty = 1'b1;
    w_allFull    = 1'b1;
    w_overflow   = 1'b0;
    for (int s = 0; s < LD; s++) begin
      if (r_fwdValid[s] || (r_crdPipe[s] != '0)) w_pipesEmpty = 1'b0;
    end
    for (int i = 0; i < V; i++) begin
      if (r_cnt[i] != FULL) w_allFull = 1'b0;
      if (w_inc[i] && !w_dec[i] && (r_cnt[i] == FULL)) w_overflow = 1'b1;
    end
  end

  assign w_violation = (link.up_flit_wr && !w_accept) || w_overflow ||
                       ((r_state == ST_OFF) && (link.dn_credit_in != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LD; s++) begin
        r_fwdValid[s] <= 1'b0;
        r_fwdFlit[s]  <= '0;
        r_fwdVc[s]    <= '0;
        r_crdPipe[s]  <= '0;
      end
    end else begin
      r_fwdValid[0] <= w_accept;
      r_fwdFlit[0]  <= w_accept ? link.up_flit : '0;
      r_fwdVc[0]    <= w_accept ? link.up_vc : '0;
      r_crdPipe[0]  <= w_crdIn;
      for (int s = 1; s < LD; s++) begin
        r_fwdValid[s] <= r_fwdValid[s-1];
        r_fwdFlit[s]  <= r_fwdFlit[s-1];
        r_fwdVc[s]    <= r_fwdVc[s-1];
        r_crdPipe[s]  <= r_crdPipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < V; i++) r_cnt[i] <= FULL;
      r_creditErr <= 1'b0;
    end else begin
      for (int i = 0; i < V; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_cnt[i] != FULL)) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
      if (w_violation) r_creditErr <= 1'b1;
    end
  end

  // Dropping sleep_req always wins; OFF is only entered once nothing is in flight and all credits are home.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACTIVE;
    end else begin
      case (r_state)
        ST_ACTIVE: if (sleep_req) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!sleep_req) r_state <= ST_ACTIVE;
          else if (w_pipesEmpty && w_allFull) r_state <= ST_OFF;
        end
        ST_OFF:    if (!sleep_req) r_state <= ST_ACTIVE;
        default:   r_state <= ST_ACTIVE;
      endcase
    end
  end

  assign link.up_credit_avail = w_avail;
  assign link.dn_flit_wr      = r_fwdValid[LD-1];
  assign link.dn_flit         = r_fwdFlit[LD-1];
  assign link.dn_vc           = r_fwdVc[LD-1];
  assign link_state           = r_state;
  assign link_idle            = (r_state == ST_OFF);
  assign credit_err           = r_creditErr;

endmodule

// File: tb/tb_mesh_torus_link_pipe.sv
// Scoreboard bench for mesh_torus_link_pipe: a time-stamped behavioural model predicts
// credits, link state and error flag, while a separate monitor checks every emitted flit.
module tb_mesh_torus_link_pipe;

  localparam int Fw = 32;
  localparam int V  = 2;
  localparam int B  = 4;
  localparam int LD = 2;

  typedef struct {
    logic [Fw-1:0] flit;
    logic [V-1:0]  vc;
    int            due;
  } exp_t;

  typedef struct {
    int vc;
    int due;
  } crd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sleep_req;
  logic [1:0] link_state;
  logic       link_idle;
  logic       credit_err;

  mesh_torus_link_pipe_if #(.Fw(Fw), .V(V)) link ();

  mesh_torus_link_pipe #(
    .NOC_ID(0), .Fw(Fw), .V(V), .B(B), .LINK_DEPTH(LD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sleep_req  (sleep_req),
    .link_state (link_state),
    .link_idle  (link_idle),
    .credit_err (credit_err),
    .link       (link)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sbQ[$];
  exp_t sbKeep[$];
  crd_t mCrd[$];
  int   mFlitDue[$];
  int   mCnt[V];
  int   mState = 0;
  bit   mErr = 1'b0;
  bit   modelLive = 1'b0;
  bit   sleepHold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [Fw-1:0] flit,
                               input logic [V-1:0] vc, input logic [V-1:0] crd, input logic slp);
    @(posedge clk);
    #1;
    reset             = rst;
    link.up_flit_wr   = wr;
    link.up_flit      = flit;
    link.up_vc        = vc;
    link.dn_credit_in = crd;
    sleep_req         = slp;
  endtask

  task automatic idle(input int n, input logic slp);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, '0, '0, slp);
  endtask

  // Reference model: credits and flits are tracked as timestamped events rather than pipeline stages.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mState = 0;
      mErr   = 1'b0;
      for (int i = 0; i < V; i++) mCnt[i] = B;
      mCrd.delete();
      mFlitDue.delete();
      sbKeep.delete();
      foreach (sbQ[k]) if (sbQ[k].due <= cyc) sbKeep.push_back(sbQ[k]);
      sbQ = sbKeep;
      modelLive = 1'b1;
    end else if (modelLive) begin
      bit            empty, allFull, accept, errNext, inc, dec;
      int            vcIdx;
      logic [V-1:0]  expAvail;
      while (mFlitDue.size() > 0 && mFlitDue[0] < cyc) void'(mFlitDue.pop_front());
      while (mCrd.size() > 0 && mCrd[0].due < cyc) void'(mCrd.pop_front());
      empty   = (mFlitDue.size() == 0) && (mCrd.size() == 0);
      allFull = 1'b1;
      for (int i = 0; i < V; i++) begin
        if (mCnt[i] != B) allFull = 1'b0;
        expAvail[i] = (mState == 0) && (mCnt[i] > 0);
      end
      checkOutput("link_state", 32'(link_state), 32'(mState));
      checkOutput("link_idle", 32'(link_idle), 32'(mState == 2));
      checkOutput("credit_err", 32'(credit_err), 32'(mErr));
      checkOutput("up_credit_avail", 32'(link.up_credit_avail), 32'(expAvail));

      vcIdx = 0;
      for (int i = 0; i < V; i++) if (link.up_vc[i]) vcIdx = i;
      accept  = link.up_flit_wr && ($countones(link.up_vc) == 1) && (mState == 0) && (mCnt[vcIdx] > 0);
      errNext = mErr;
      if (accept) begin
        sbQ.push_back('{link.up_flit, link.up_vc, cyc + LD});
        mFlitDue.push_back(cyc + LD);
      end else if (link.up_flit_wr) begin
        errNext = 1'b1;
      end
      for (int i = 0; i < V; i++) begin
        if (link.dn_credit_in[i]) begin
          if (mState == 2) errNext = 1'b1;
          else mCrd.push_back('{i, cyc + LD});
        end
      end
      for (int i = 0; i < V; i++) begin
        inc = 1'b0;
        foreach (mCrd[k]) if (mCrd[k].due == cyc && mCrd[k].vc == i) inc = 1'b1;
        dec = accept && (vcIdx == i);
        if (inc && !dec) begin
          if (mCnt[i] == B) errNext = 1'b1;
          else mCnt[i]++;
        end else if (dec && !inc) begin
          mCnt[i]--;
        end
      end
      case (mState)
        0: if (sleep_req) mState = 1;
        1: if (!sleep_req) mState = 0; else if (empty && allFull) mState = 2;
        default: if (!sleep_req) mState = 0;
      endcase
      mErr = errNext;
    end
  end

  // Monitor: every downstream write must match the oldest expected flit and arrive exactly on time.
  always @(negedge clk) begin
    if (link.dn_flit_wr === 1'b1) begin
      if (sbQ.size() == 0 || sbQ[0].due != cyc) begin
        checkOutput("dn_flit_wr_unexpected", 32'(link.dn_flit_wr), 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("dn_flit", link.dn_flit, e.flit);
        checkOutput("dn_vc", 32'(link.dn_vc), 32'(e.vc));
      end
    end else if (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
      checkOutput("dn_flit_wr_missing", 32'(link.dn_flit_wr), 32'd1);
      void'(sbQ.pop_front());
    end
  end

  initial begin
    reset             = 1'b1;
    sleep_req         = 1'b0;
    link.up_flit_wr   = 1'b0;
    link.up_flit      = '0;
    link.up_vc        = '0;
    link.dn_credit_in = '0;

    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(6, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hA5A5A5A5, 2'b01, '0, 1'b0);
    idle(4, 1'b0);

    // Drain VC1 completely, then one extra write that must be dropped.
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, $urandom, 2'b10, '0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b10, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 2'b10, 2'b10, 1'b0);
    idle(4, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 2'b11, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 2'b00, '0, 1'b0);
    idle(2, 1'b0);

    // Sleep with two flits in flight and two credits outstanding.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 2'b01, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 2'b01, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b01, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b01, 1'b1);
    idle(8, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b10, 1'b1);
    idle(2, 1'b1);
    idle(3, 1'b0);

    // Credit overflow on a full counter.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b01, 1'b0);
    idle(5, 1'b0);

    // Reset while flits are in flight.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 2'b01, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 2'b10, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(5, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic         rst, wr;
      logic [V-1:0] vc, crd;
      int           pick;
      rst  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) sleepHold = ~sleepHold;
      wr   = $urandom_range(0, 1) == 1;
      pick = $urandom_range(0, 9);
      if (pick <= 4) vc = 2'b01;
      else if (pick <= 8) vc = 2'b10;
      else vc = V'($urandom_range(0, 3));
      crd[0] = ($urandom_range(0, 99) < 15);
      crd[1] = ($urandom_range(0, 99) < 15);
      applyStimulus(rst, wr, $urandom, vc, crd, sleepHold);
    end
    idle(10, 1'b0);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
